clk_div_bank: RTL

Multi-channel, run-time programmable clock-enable and divided-clock generator. It runs from the single PLL output clock and produces phase-aligned, lock-gated per-channel divided clocks and one-cycle tick pulses for the CPU, video and peripheral timing domains. It extends the fixed single-output PLL wrapper with N channels, per-channel divisors reprogrammable without glitches, and a synthetic lock sequence.

---
 rtl/clk_div_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel programmable divided-clock and tick generator gated by a synthetic PLL lock count.
// Optional CLK_DIV_BANK_RESYNC_EN adds a `resync` input that realigns every enabled channel to cnt=0.
`timescale 1ns/1ps
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 5,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
`ifdef CLK_DIV_BANK_RESYNC_EN
  input  logic              resync,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  logic [LCW-1:0]    lock_cnt_reg;
  logic              locked_reg;
  logic              locked_next;
  logic              resync_now;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pend_valid;

  // Channels see the lock decision of this edge so they start in the first locked cycle.
  assign locked_next = locked_reg | (lock_cnt_reg == LOCK_LAST);
  assign locked      = locked_reg;

`ifdef CLK_DIV_BANK_RESYNC_EN
  assign resync_now = resync & locked_reg;
`else
  assign resync_now = 1'b0;
`endif

  // Out-of-range channel indices match no channel, so they are accepted and dropped.
  assign cfg_ready = ~|(hit & pend_valid);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else begin
      if (!locked_reg) begin
        lock_cnt_reg <= lock_cnt_reg + LCW'(1);
      end
      locked_reg <= locked_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pend_reg;
    logic             pend_valid_reg;
    logic             run_reg;
    logic             outclk_reg;
    logic             tick_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W:0]   high_len;
    logic             run_now;
    logic             restart;
    logic             wrap;
    logic             apply;
    logic             accept;

    assign hit[gi]        = (cfg_ch == CH_W'(gi));
    assign pend_valid[gi] = pend_valid_reg;
    assign outclk[gi]     = outclk_reg;
    assign tick[gi]       = tick_reg;

    always_comb begin
      accept   = cfg_valid & cfg_ready & hit[gi];
      run_now  = locked_next & ch_en[gi];
      // A channel coming out of idle (lock rise, re-enable) or a resync begins a fresh period.
      restart  = run_now & (~run_reg | resync_now);
      wrap     = run_now & run_reg & (cnt_reg == div_reg - DIV_ONE);
      // Divisor changes only at period boundaries, or immediately while idle.
      apply    = pend_valid_reg & (~run_now | restart | wrap);
      div_next = apply ? pend_reg : div_reg;
      cnt_next = (run_now & ~restart & ~wrap) ? cnt_reg + DIV_ONE : '0;
      high_len = ({1'b0, div_next} + (DIV_W+1)'(1)) >> 1;
    end

    // Outputs are registered from next-state so they track the cnt register in the same cycle.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        cnt_reg        <= '0;
        div_reg        <= DIV_RST;
        pend_reg       <= DIV_RST;
        pend_valid_reg <= 1'b0;
        run_reg        <= 1'b0;
        outclk_reg     <= 1'b0;
        tick_reg       <= 1'b0;
      end else begin
        cnt_reg    <= cnt_next;
        div_reg    <= div_next;
        run_reg    <= run_now;
        outclk_reg <= run_now & ({1'b0, cnt_next} < high_len);
        tick_reg   <= run_now & (cnt_next == '0);
        if (accept) begin
          pend_reg       <= (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
          pend_valid_reg <= 1'b1;
        end else if (apply) begin
          pend_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule
